hdmi_timing_pattern_gen: RTL and testbench

- Video timing and test-pattern generator that sits directly downstream of the HDMI AXI4-Lite slave register block.
- Consumes that block's slave registers (control, colour); produces hsync/vsync/de/RGB for the TMDS/DVI encoder.
- Reports run and frame status back through a read-only status word, which the register block maps to slv_reg3.

---
 rtl/hdmi_tpg_pkg.sv | 51 +++++
 rtl/hdmi_tpg_pattern.sv | 77 +++++++
 rtl/hdmi_timing_pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_hdmi_timing_pattern_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tpg_pkg.sv
// rtl/hdmi_tpg_pkg.sv - shared types, bit positions and bar colours for the HDMI timing/pattern generator
// Purpose: pattern and state enums, ctrl/status bit positions, colour-bar palette.
// Ports: none (package).
// Optional feature macro used by the top: HDMI_FRAME_IRQ_EN.
package hdmi_tpg_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_CHECKER = 2'd3
  } pattern_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_PAT_LSB    = 1;
  localparam int CTRL_PAT_MSB    = 2;
  localparam int STAT_RUN_BIT    = 0;
  localparam int STAT_VBLANK_BIT = 1;
  localparam int STAT_FCNT_LSB   = 16;
  localparam int STAT_FCNT_MSB   = 31;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hdmi_tpg_pattern.sv
// rtl/hdmi_tpg_pattern.sv - test-pattern pixel generator with registered rgb output
// Purpose: turns the current h/v counter and shadow pattern/colour into a pixel,
//          registered so it lines up with the registered sync/de outputs.
// Ports:
//   i_clk, i_rst_n  pixel clock, asynchronous active-low reset
//   i_h, i_v        current counter position
//   i_de            pixel at i_h/i_v is active (forces black when low)
//   i_pattern       shadow pattern select
//   i_color         shadow solid colour {R,G,B}
//   o_rgb           registered pixel
module hdmi_tpg_pattern
  import hdmi_tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int CNT_W    = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [CNT_W-1:0] i_h,
  input  logic [CNT_W-1:0] i_v,
  input  logic             i_de,
  input  pattern_e         i_pattern,
  input  logic [23:0]      i_color,
  output logic [23:0]      o_rgb
);

  localparam int               BAR_W      = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] L_BAR_LAST = CNT_W'(BAR_W - 1);

  // r_bar_cnt/r_bar_idx describe the pixel presented on the previous cycle;
  // h advances by one per cycle, so the current bar follows from them
  // without any division.
  logic [CNT_W-1:0] r_bar_cnt;
  logic [2:0]       r_bar_idx;
  logic [CNT_W-1:0] w_bar_cnt;
  logic [2:0]       w_bar_idx;
  logic [23:0]      w_rgb;
  logic             w_unused_v;

  assign w_unused_v = ^{i_v[CNT_W-1:6], i_v[4:0]};

  always_comb begin
    w_bar_cnt = r_bar_cnt + CNT_W'(1);
    w_bar_idx = r_bar_idx;
    if (i_h == '0) begin
      w_bar_cnt = '0;
      w_bar_idx = 3'd0;
    end else if (r_bar_cnt == L_BAR_LAST) begin
      w_bar_cnt = '0;
      w_bar_idx = r_bar_idx + 3'd1;
    end
  end

  always_comb begin
    w_rgb = '0;
    case (i_pattern)
      PAT_SOLID:   w_rgb = i_color;
      PAT_BARS:    w_rgb = bar_color(w_bar_idx);
      PAT_RAMP:    w_rgb = {i_h[7:0], i_h[7:0], i_h[7:0]};
      PAT_CHECKER: w_rgb = (i_h[5] ^ i_v[5]) ? COL_WHITE : COL_BLACK;
      default:     w_rgb = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_cnt <= '0;
      r_bar_idx <= 3'd0;
      o_rgb     <= '0;
    end else begin
      r_bar_cnt <= w_bar_cnt;
      r_bar_idx <= w_bar_idx;
      o_rgb     <= i_de ? w_rgb : 24'd0;
    end
  end

endmodule

// File: rtl/hdmi_timing_pattern_gen.sv
// rtl/hdmi_timing_pattern_gen.sv - video timing generator and test-pattern source for the TMDS encoder
// Purpose: IDLE/RUN FSM with h/v counters, sync/de decode, frame-boundary shadow capture,
//          status word for the register block.
// Ports:
//   ACLK, ARESETN  pixel clock, asynchronous active-low reset
//   ctrl_reg       bit0 enable, bits[2:1] pattern
//   color_reg      bits[23:0] solid colour
//   status_reg     bit0 running, bit1 in_vblank, bits[31:16] frame count
//   hsync, vsync, de, rgb  registered video outputs (latency 1 from counters)
//   frame_irq      (only with HDMI_FRAME_IRQ_EN) one-cycle pulse at start of vblank
module hdmi_timing_pattern_gen
  import hdmi_tpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [31:0] ctrl_reg,
  input  logic [31:0] color_reg,
  output logic [31:0] status_reg,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb
`ifdef HDMI_FRAME_IRQ_EN
  ,
  output logic        frame_irq
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] L_H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] L_H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] L_HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] L_V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] L_V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] L_VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] L_VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_h, r_v, w_h_nxt, w_v_nxt;
  pattern_e         r_pat, w_pat_nxt;
  logic [23:0]      r_color, w_color_nxt;
  logic [15:0]      r_frame_cnt, w_frame_cnt_nxt;
  logic             r_hsync, r_vsync, r_de;

  logic w_enable, w_run, w_h_wrap, w_v_wrap;
  logic w_active, w_hs_on, w_vs_on;
  logic w_unused_bits;

  assign w_unused_bits = ^{ctrl_reg[31:CTRL_PAT_MSB+1], color_reg[31:24]};

  assign w_enable = ctrl_reg[CTRL_EN_BIT];
  assign w_run    = (r_state == ST_RUN);
  assign w_h_wrap = (r_h == L_H_LAST);
  assign w_v_wrap = (r_v == L_V_LAST);

  // Next state, counters and shadows. Shadows only move when a frame starts,
  // so register writes mid-frame wait for the next frame.
  always_comb begin
    w_state_nxt     = r_state;
    w_h_nxt         = r_h;
    w_v_nxt         = r_v;
    w_pat_nxt       = r_pat;
    w_color_nxt     = r_color;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      ST_IDLE: begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (w_enable) begin
          w_state_nxt = ST_RUN;
          w_pat_nxt   = pattern_e'(ctrl_reg[CTRL_PAT_MSB:CTRL_PAT_LSB]);
          w_color_nxt = color_reg[23:0];
        end
      end
      ST_RUN: begin
        if (w_h_wrap) begin
          w_h_nxt = '0;
          if (w_v_wrap) begin
            w_v_nxt         = '0;
            w_frame_cnt_nxt = r_frame_cnt + 16'd1;
            if (w_enable) begin
              w_pat_nxt   = pattern_e'(ctrl_reg[CTRL_PAT_MSB:CTRL_PAT_LSB]);
              w_color_nxt = color_reg[23:0];
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_v_nxt = r_v + CNT_W'(1);
          end
        end else begin
          w_h_nxt = r_h + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_IDLE;
      r_h         <= '0;
      r_v         <= '0;
      r_pat       <= PAT_SOLID;
      r_color     <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      r_pat       <= w_pat_nxt;
      r_color     <= w_color_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // Decode is gated by RUN because the held-at-zero counters in IDLE would
  // otherwise look like the first active pixel.
  assign w_active = w_run && (r_h < L_H_ACT) && (r_v < L_V_ACT);
  assign w_hs_on  = w_run && (r_h >= L_HS_BEG) && (r_h < L_HS_END);
  assign w_vs_on  = w_run && (r_v >= L_VS_BEG) && (r_v < L_VS_END);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
    end else begin
      r_hsync <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_active;
    end
  end

  hdmi_tpg_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .CNT_W    (CNT_W)
  ) u_pattern (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_h       (r_h),
    .i_v       (r_v),
    .i_de      (w_active),
    .i_pattern (r_pat),
    .i_color   (r_color),
    .o_rgb     (rgb)
  );

  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign de    = r_de;

  always_comb begin
    status_reg                                = '0;
    status_reg[STAT_RUN_BIT]                  = w_run;
    status_reg[STAT_VBLANK_BIT]               = w_run && (r_v >= L_V_ACT);
    status_reg[STAT_FCNT_MSB:STAT_FCNT_LSB]   = r_frame_cnt;
  end

`ifdef HDMI_FRAME_IRQ_EN
  logic r_irq;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_run && (r_h == '0) && (r_v == L_V_ACT);
    end
  end

  assign frame_irq = r_irq;
`endif

endmodule

// File: tb/tb_hdmi_timing_pattern_gen.sv
// tb/tb_hdmi_timing_pattern_gen.sv - scoreboard bench for hdmi_timing_pattern_gen
module tb_hdmi_timing_pattern_gen;

  localparam int HA = 16, HFP = 2, HS = 2, HBP = 4;
  localparam int VA = 4,  VFP = 1, VS = 1, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [31:0] ctrl_reg = 32'd0;
  logic [31:0] color_reg = 32'd0;
  logic [31:0] status_reg;
  logic        hsync, vsync, de;
  logic [23:0] rgb;
  logic        frame_irq;

  always #5 ACLK = ~ACLK;

  hdmi_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .SYNC_POL (1'b1), .CNT_W (12)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .ctrl_reg   (ctrl_reg),
    .color_reg  (color_reg),
    .status_reg (status_reg),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb)
`ifdef HDMI_FRAME_IRQ_EN
    ,
    .frame_irq  (frame_irq)
`endif
  );

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [31:0] status;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model: a running flag plus a linear pixel position within the frame.
  bit          m_run  = 1'b0;
  int          m_pos  = 0;
  logic [1:0]  m_pat  = 2'd0;
  logic [23:0] m_col  = 24'd0;
  int          m_fcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] pixel(input int h, input int v, input logic [1:0] pat,
                                        input logic [23:0] col);
    logic [7:0] hb;
    hb = 8'(h);
    case (pat)
      2'd0:    return col;
      2'd1:    return bar_tab[h / (HA / 8)];
      2'd2:    return {hb, hb, hb};
      default: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  task automatic model_step();
    exp_t e;
    int   h, v;
    logic vb;
    e = '{default: '0};
    if (!ARESETN) begin
      m_run = 1'b0; m_pos = 0; m_pat = 2'd0; m_col = 24'd0; m_fcnt = 0;
    end else begin
      h = m_pos % HT;
      v = m_pos / HT;
      e.de  = m_run && (h < HA) && (v < VA);
      e.hs  = m_run && (h >= HA + HFP) && (h < HA + HFP + HS);
      e.vs  = m_run && (v >= VA + VFP) && (v < VA + VFP + VS);
      e.rgb = e.de ? pixel(h, v, m_pat, m_col) : 24'd0;
      e.irq = m_run && (h == 0) && (v == VA);
      if (!m_run) begin
        if (ctrl_reg[0]) begin
          m_run = 1'b1; m_pos = 0; m_pat = ctrl_reg[2:1]; m_col = color_reg[23:0];
        end
      end else if (m_pos == FRAME - 1) begin
        m_fcnt = (m_fcnt + 1) % 65536;
        m_pos  = 0;
        if (ctrl_reg[0]) begin
          m_pat = ctrl_reg[2:1]; m_col = color_reg[23:0];
        end else begin
          m_run = 1'b0;
        end
      end else begin
        m_pos++;
      end
      vb = m_run && ((m_pos / HT) >= VA);
      e.status = {m_fcnt[15:0], 14'd0, vb, m_run};
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge ACLK);
    model_step();
  end

  initial forever begin
    exp_t e;
    @(negedge ACLK);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("de", {31'd0, de}, {31'd0, e.de});
      chk("hsync", {31'd0, hsync}, {31'd0, e.hs});
      chk("vsync", {31'd0, vsync}, {31'd0, e.vs});
      chk("rgb", {8'd0, rgb}, {8'd0, e.rgb});
      chk("status", status_reg, e.status);
`ifdef HDMI_FRAME_IRQ_EN
      chk("frame_irq", {31'd0, frame_irq}, {31'd0, e.irq});
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic wait_pos(input int target, input int budget);
    int k;
    k = 0;
    while (!(m_run && m_pos == target) && k < budget) begin
      @(negedge ACLK);
      k++;
    end
    chk("wait_pos_timeout", {31'd0, (m_run && m_pos == target)}, 32'd1);
  endtask

  task automatic count_window();
    int n_de, n_hs, n_vs;
    n_de = 0; n_hs = 0; n_vs = 0;
    repeat (FRAME) begin
      @(negedge ACLK);
      n_de += int'(de);
      n_hs += int'(hsync);
      n_vs += int'(vsync);
    end
    chk("de_per_frame", n_de, 64);
    chk("hsync_per_frame", n_hs, 16);
    chk("vsync_per_frame", n_vs, 24);
  endtask

  initial begin
    int k;
    #1 ARESETN = 1'b0;
    cyc(10);
    ARESETN = 1'b1;
    cyc(500);

    // Start, then drop enable mid-frame at h=5, v=2: frame must complete.
    color_reg = 32'h0012_3456;
    ctrl_reg  = 32'd1;
    wait_pos(2 * HT + 5, 400);
    ctrl_reg = 32'd0;
    k = 0;
    while (m_run && k < 2 * FRAME) begin
      @(negedge ACLK);
      k++;
    end
    chk("stop_timeout", {31'd0, m_run}, 32'd0);
    cyc(2);
    chk("stop_status", status_reg, 32'h0001_0000);

    // Solid colour, steady-state timing counts.
    ctrl_reg = 32'd1;
    cyc(FRAME + 10);
    count_window();

    // Mid-frame colour write waits for the next frame.
    wait_pos(HT + 3, 2 * FRAME);
    color_reg = 32'h00AB_CDEF;
    cyc(2 * FRAME);

    ctrl_reg = 32'd3; cyc(2 * FRAME + 5);
    ctrl_reg = 32'd5; cyc(2 * FRAME + 5);
    ctrl_reg = 32'd7; cyc(2 * FRAME + 5);

    for (int i = 0; i < 30; i++) begin
      cyc($urandom_range(1, 250));
      ctrl_reg  = $urandom;
      if ($urandom_range(0, 3) != 0) ctrl_reg[0] = 1'b1;
      color_reg = $urandom;
    end

    // Asynchronous reset at h=10, v=1 must clear outputs before any clock edge.
    ctrl_reg = 32'd1;
    cyc(3 * FRAME);
    wait_pos(HT + 10, 2 * FRAME);
    #1 ARESETN = 1'b0;
    #1;
    chk("async_de", {31'd0, de}, 32'd0);
    chk("async_rgb", {8'd0, rgb}, 32'd0);
    chk("async_hsync", {31'd0, hsync}, 32'd0);
    chk("async_vsync", {31'd0, vsync}, 32'd0);
    chk("async_status", status_reg, 32'd0);
    cyc(3);
    ARESETN = 1'b1;
    cyc(2 * FRAME);
    ctrl_reg = 32'd0;
    cyc(FRAME + 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
